// File: rtl/operand_forward_pkg.sv
// operand_forward_pkg: shared encodings, tag type and select helper for the bypass unit
package operand_forward_pkg;

    localparam int RD_W = 4;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [RD_W-1:0] PC_IDX = 4'd15;

    typedef struct packed {
        logic            valid;
        logic            is_load;
        logic [RD_W-1:0] rd;
    } tag_t;

    // Youngest producer wins; a load still in EX is left to the stall logic.
    function automatic logic [1:0] pick(input logic used, input logic [RD_W-1:0] s,
                                        input tag_t ex, input tag_t mem);
        return (!used || s == PC_IDX) ? SEL_RF :
               (ex.valid && !ex.is_load && ex.rd == s) ? SEL_MEM :
               (mem.valid && mem.rd == s) ? SEL_WB : SEL_RF;
    endfunction

endpackage

// File: rtl/operand_forward_instr_tag_decode.sv
// instr_tag_decode: destination tag and source-use decode of one instruction word
module instr_tag_decode
    import operand_forward_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 4
) (
    input  logic [INSTR_W-1:0] instr,
    output tag_t               tag,
    output logic [REG_AW-1:0]  rn,
    output logic [REG_AW-1:0]  rm,
    output logic               rn_used,
    output logic               rm_used
);

    logic [1:0] cls;
    logic       wr_dp;
    logic       wr_ld;

    // Compare-class data-processing ops and r15 destinations never produce a tag.
    always_comb begin
        cls         = instr[27:26];
        wr_dp       = cls == OP_DP && instr[24:23] != 2'b10;
        wr_ld       = cls == OP_MEM && instr[20];
        tag.rd      = instr[15:12];
        tag.is_load = wr_ld;
        tag.valid   = (wr_dp || wr_ld) && instr[15:12] != PC_IDX;
        rn          = instr[19:16];
        rm          = instr[3:0];
        rn_used     = cls == OP_DP || cls == OP_MEM;
        rm_used     = (cls == OP_DP && !instr[25]) || (cls == OP_MEM && instr[25]);
    end

endmodule

// File: rtl/operand_forward.sv
// operand_forward: registered EX-stage bypass selects from in-flight destination tags
module operand_forward
    import operand_forward_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction_reg_file,
    input  logic               stall,
    input  logic               flush,
    output logic [1:0]         fwd_rn_sel,
    output logic [1:0]         fwd_rm_sel,
    output logic [CNT_W-1:0]   fwd_count
);

    tag_t              rf_tag;
    tag_t              tag_ex;
    tag_t              tag_mem;
    tag_t              tag_wb;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rm;
    logic              rn_used;
    logic              rm_used;
    logic              bubble;
    logic [1:0]        rn_nxt;
    logic [1:0]        rm_nxt;
    logic              hit;

    instr_tag_decode #(.INSTR_W(INSTR_W), .REG_AW(REG_AW)) u_dec (
        .instr   (instruction_reg_file),
        .tag     (rf_tag),
        .rn      (rn),
        .rm      (rm),
        .rn_used (rn_used),
        .rm_used (rm_used)
    );

    // Selects for the instruction about to enter EX, compared against tags before they shift.
    always_comb begin
        bubble = stall || flush;
        rn_nxt = bubble ? SEL_RF : pick(rn_used, rn, tag_ex, tag_mem);
        rm_nxt = bubble ? SEL_RF : pick(rm_used, rm, tag_ex, tag_mem);
        hit    = rn_nxt != SEL_RF || rm_nxt != SEL_RF;
    end

    // Tag pipeline, registered selects and saturating forward-event counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_ex     <= '0;
            tag_mem    <= '0;
            tag_wb     <= '0;
            fwd_rn_sel <= SEL_RF;
            fwd_rm_sel <= SEL_RF;
            fwd_count  <= '0;
        end else begin
            tag_wb     <= tag_mem;
            tag_mem    <= tag_ex;
            tag_ex     <= bubble ? '0 : rf_tag;
            fwd_rn_sel <= rn_nxt;
            fwd_rm_sel <= rm_nxt;
            fwd_count  <= (hit && !(&fwd_count)) ? fwd_count + 1'b1 : fwd_count;
        end
    end

endmodule

// File: tb/tb_operand_forward.sv
// tb_operand_forward: directed vectors with a queued scoreboard for the bypass unit
module tb_operand_forward;

    localparam logic [31:0] ADD_R1_R2_R3 = 32'hE0821003;
    localparam logic [31:0] ADD_R4_R1_R1 = 32'hE0814001;
    localparam logic [31:0] MOV_R0_R0    = 32'hE1A00000;
    localparam logic [31:0] LDR_R1_R2    = 32'hE5921000;
    localparam logic [31:0] BR           = 32'hEA000000;
    localparam logic [31:0] MOV_PC_R1    = 32'hE1A0F001;
    localparam logic [31:0] ADD_R4_PC_PC = 32'hE08F400F;
    localparam logic [31:0] ADD_R1_R1_R1 = 32'hE0811001;

    typedef struct {
        logic [1:0]  rn;
        logic [1:0]  rm;
        logic [15:0] cnt;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic [1:0]  fwd_rn_sel;
    logic [1:0]  fwd_rm_sel;
    logic [15:0] fwd_count;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          vec_id = 0;
    logic [15:0] exp_cnt = '0;

    operand_forward dut (
        .clk                  (clk),
        .reset                (reset),
        .instruction_reg_file (instr),
        .stall                (stall),
        .flush                (flush),
        .fwd_rn_sel           (fwd_rn_sel),
        .fwd_rm_sel           (fwd_rm_sel),
        .fwd_count            (fwd_count)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [31:0] i, input logic s, input logic f,
                        input logic [1:0] ern, input logic [1:0] erm);
        instr = i;
        stall = s;
        flush = f;
        if ((ern != 2'b00 || erm != 2'b00) && exp_cnt != 16'hFFFF) exp_cnt++;
        q.push_back('{ern, erm, exp_cnt, vec_id});
        vec_id++;
        @(negedge clk);
    endtask

    task automatic fill(input int n);
        for (int k = 0; k < n; k++) step(BR, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic direct(input string name, input logic [1:0] ern, input logic [1:0] erm,
                          input logic [15:0] ecnt);
        checks++;
        if (fwd_rn_sel !== ern || fwd_rm_sel !== erm || fwd_count !== ecnt) begin
            errors++;
            $display("FAIL %s: got rn=%b rm=%b cnt=%0d, want rn=%b rm=%b cnt=%0d",
                     name, fwd_rn_sel, fwd_rm_sel, fwd_count, ern, erm, ecnt);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (fwd_rn_sel !== e.rn || fwd_rm_sel !== e.rm || fwd_count !== e.cnt) begin
                    errors++;
                    $display("FAIL vec%0d: got rn=%b rm=%b cnt=%0d, want rn=%b rm=%b cnt=%0d",
                             e.id, fwd_rn_sel, fwd_rm_sel, fwd_count, e.rn, e.rm, e.cnt);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        instr = BR;
        stall = 1'b0;
        flush = 1'b0;
        #1;
        direct("reset_state", 2'b00, 2'b00, 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        step(ADD_R1_R2_R3, 1'b0, 1'b0, 2'b00, 2'b00);
        step(ADD_R4_R1_R1, 1'b0, 1'b0, 2'b01, 2'b01);
        fill(3);

        step(ADD_R1_R2_R3, 1'b0, 1'b0, 2'b00, 2'b00);
        step(MOV_R0_R0,    1'b0, 1'b0, 2'b00, 2'b00);
        step(ADD_R4_R1_R1, 1'b0, 1'b0, 2'b10, 2'b10);
        fill(3);

        step(LDR_R1_R2,    1'b0, 1'b0, 2'b00, 2'b00);
        step(ADD_R4_R1_R1, 1'b1, 1'b0, 2'b00, 2'b00);
        step(ADD_R4_R1_R1, 1'b0, 1'b0, 2'b10, 2'b10);
        fill(3);

        step(LDR_R1_R2,    1'b0, 1'b0, 2'b00, 2'b00);
        step(ADD_R4_R1_R1, 1'b0, 1'b0, 2'b00, 2'b00);
        fill(3);

        step(ADD_R1_R2_R3, 1'b0, 1'b0, 2'b00, 2'b00);
        step(BR,           1'b0, 1'b0, 2'b00, 2'b00);
        fill(2);
        step(MOV_PC_R1,    1'b0, 1'b0, 2'b00, 2'b00);
        step(ADD_R4_PC_PC, 1'b0, 1'b0, 2'b00, 2'b00);
        step(ADD_R4_PC_PC, 1'b0, 1'b0, 2'b00, 2'b00);
        fill(3);

        step(ADD_R1_R2_R3, 1'b0, 1'b1, 2'b00, 2'b00);
        step(ADD_R4_R1_R1, 1'b0, 1'b0, 2'b00, 2'b00);
        fill(3);
        step(ADD_R1_R2_R3, 1'b1, 1'b1, 2'b00, 2'b00);
        step(ADD_R4_R1_R1, 1'b0, 1'b0, 2'b00, 2'b00);
        fill(3);

        step(ADD_R1_R2_R3, 1'b0, 1'b0, 2'b00, 2'b00);
        step(ADD_R4_R1_R1, 1'b0, 1'b0, 2'b01, 2'b01);
        direct("pre_reset", 2'b01, 2'b01, exp_cnt);
        #2;
        reset = 1'b1;
        #1;
        direct("async_reset", 2'b00, 2'b00, 16'd0);
        exp_cnt = '0;
        @(negedge clk);
        reset = 1'b0;
        step(ADD_R4_R1_R1, 1'b0, 1'b0, 2'b00, 2'b00);
        fill(2);

        step(ADD_R1_R1_R1, 1'b0, 1'b0, 2'b00, 2'b00);
        reset = 1'b1;
        #1;
        exp_cnt = '0;
        @(negedge clk);
        q.delete();
        reset = 1'b0;
        step(ADD_R1_R1_R1, 1'b0, 1'b0, 2'b00, 2'b00);
        for (int k = 0; k < 65541; k++) step(ADD_R1_R1_R1, 1'b0, 1'b0, 2'b01, 2'b01);
        direct("saturated", 2'b01, 2'b01, 16'hFFFF);

        for (int k = 0; k < 5 && q.size() != 0; k++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
